spi_ram_bridge: RTL
===================

SPI_RAM_BRIDGE -- requirements
Module: spi_ram_bridge

Interface
REQ-001 Parameter DATA_W, default 8, RAM word width in bits (range 4..32).
REQ-002 Parameter ADDR_W, default 8, RAM address width in bits (range 4..16).
REQ-003 Parameter MEM_DEPTH, default 256, number of RAM words; SHALL satisfy MEM_DEPTH <= 2**ADDR_W.
REQ-004 Derived PAYLOAD_W = max(ADDR_W, DATA_W); frame length FRAME_W = PAYLOAD_W + 2.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 SS_n  input  1  slave select, active-low, frames a transaction.
REQ-008 MOSI  input  1  serial data in, MSB first.
REQ-009 MISO  output  1  serial read data out, MSB first.

Function
REQ-010 The FSM SHALL have states IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
REQ-011 IDLE -> CHK_CMD on a rising edge with SS_n=0; MOSI is ignored on that edge.
REQ-012 In CHK_CMD, MOSI is sampled as cmd[1]: 0 -> WRITE; 1 with rd_addr_valid=0 -> READ_ADD; 1 with rd_addr_valid=1 -> READ_DATA.
REQ-013 The next FRAME_W-1 rising edges SHALL shift MOSI into cmd[0] then payload[PAYLOAD_W-1:0].
REQ-014 Commands: 00 load write address, 01 write payload[DATA_W-1:0] to RAM at write address, 10 load read address and set rd_addr_valid, 11 read RAM at read address and clear rd_addr_valid.
REQ-015 Addresses SHALL be taken from payload[ADDR_W-1:0]; upper payload bits are ignored.
REQ-016 The RAM write for cmd 01 SHALL occur on the edge after the last payload bit is sampled.
REQ-017 For cmd 11, MISO SHALL output RAM bit DATA_W-1 starting two edges after the last payload bit, then one bit per edge, DATA_W bits total; the FSM returns to IDLE after the last bit.
REQ-018 MISO SHALL be 0 whenever it is not shifting read data.
REQ-019 A write to address >= MEM_DEPTH SHALL be discarded; a read from address >= MEM_DEPTH SHALL return all zeros.
REQ-020 SS_n=1 in any state other than IDLE SHALL abort: return to IDLE on that edge, no RAM write, rd_addr_valid and addresses unchanged, MISO=0.
REQ-021 Commands 00/01 in READ_ADD/READ_DATA paths, or 10/11 in the WRITE path, SHALL be discarded and SHALL return the FSM to IDLE at frame end.
REQ-022 SS_n held low after frame completion SHALL keep the FSM in IDLE until SS_n rises and falls again.

Reset
REQ-023 On rising edge with rst_n=0: state IDLE, MISO=0, shift register 0, write/read addresses 0, rd_addr_valid=0, bit counter 0.
REQ-024 Reset mid-frame SHALL take priority over all other events; RAM contents are not cleared.

Configuration
REQ-025 Macro SPI_RAM_AUTOINC_EN defined: after each completed cmd 01 the write address SHALL increment by 1, and after each completed cmd 11 the read address SHALL increment by 1 and rd_addr_valid stays 1, both wrapping MEM_DEPTH-1 -> 0.
REQ-026 Macro undefined: addresses change only on cmd 00/10, and cmd 11 clears rd_addr_valid.

Structure
REQ-027 Package spi_ram_pkg SHALL hold the state enum, the 2-bit command encodings and the CMD_W=2 constant.
REQ-028 RAM SHALL be a sub-module spi_ram_mem (synchronous single-port, 1-cycle read latency, parameters DATA_W/ADDR_W/MEM_DEPTH).

Verification (defaults: DATA_W=8, ADDR_W=8, FRAME_W=10)
REQ-029 Frames 00_0x3C, 01_0xA5, 10_0x3C, 11_0x00 -> MISO serialises 1010_0101 starting two edges after frame end.
REQ-030 rst_n=0 for one edge after 5 payload bits of cmd 01 -> MISO=0, state IDLE; a following read of that address returns its prior value.
REQ-031 SS_n raised after 4 bits of 01_0xFF -> RAM unchanged; next full frame decodes correctly.
REQ-032 MEM_DEPTH=200: write 0x77 to address 0xC8, then read 0xC8 -> MISO outputs 0x00.
REQ-033 With SPI_RAM_AUTOINC_EN: 00_0xFF, 01_0x11, 01_0x22 (MEM_DEPTH=256) -> RAM[0xFF]=0x11, RAM[0x00]=0x22; without it -> RAM[0xFF]=0x22.
REQ-034 Cmd 11 sent with rd_addr_valid=0 -> treated as READ_ADD path, frame discarded, MISO stays 0.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg
//   Shared definitions for the SPI-to-RAM bridge: the bridge FSM state
//   type, the 2-bit command encodings and the command field width.
//   No ports; imported by spi_ram_bridge and spi_ram_mem.
package spi_ram_pkg;

    localparam int CMD_W = 2;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    localparam logic [CMD_W-1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [CMD_W-1:0] CMD_WR_DATA = 2'b01;
    localparam logic [CMD_W-1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [CMD_W-1:0] CMD_RD_DATA = 2'b11;

    // Payload field is wide enough to carry either an address or a data word.
    function automatic int payload_width(input int addr_w, input int data_w);
        return (addr_w > data_w) ? addr_w : data_w;
    endfunction

endpackage

// File: rtl/spi_ram_mem.sv
// spi_ram_mem
//   Synchronous single-port RAM with one cycle of read latency. The read
//   port samples addr on every rising edge; a read during a write returns
//   the old word. Addresses at or above MEM_DEPTH are not backed by storage:
//   writes there are dropped and reads return all zeros.
//   Ports:
//     clk    in   clock
//     we     in   write enable
//     addr   in   word address [ADDR_W-1:0]
//     wdata  in   write data   [DATA_W-1:0]
//     rdata  out  read data    [DATA_W-1:0], registered
module spi_ram_mem
    import spi_ram_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(MEM_DEPTH);

    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic              in_range;
    logic [IDX_W-1:0]  idx;

    assign in_range = ({1'b0, addr} < DEPTH_V);
    assign idx      = addr[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (we && in_range) begin
            mem[idx] <= wdata;
        end
        rdata <= in_range ? mem[idx] : '0;
    end

endmodule

// File: rtl/spi_ram_bridge.sv
// spi_ram_bridge
//   SPI slave (mode-0 style sampling on clk) that gives a host access to a
//   small RAM. Each frame is CMD_W command bits followed by a payload of
//   max(ADDR_W, DATA_W) bits, MSB first on MOSI:
//     00 load write address     01 write data at write address
//     10 load read address      11 read data at read address (needs a
//                                  prior 10); data returns on MISO
//   Optional build macro SPI_RAM_AUTOINC_EN: write address advances after
//   each data write and read address advances after each data read (read
//   address stays valid), both wrapping at MEM_DEPTH-1. Without it, a data
//   read consumes the read address.
//   Ports:
//     clk    in   clock, rising edge
//     rst_n  in   synchronous active-low reset
//     SS_n   in   slave select, active low; high outside IDLE aborts frame
//     MOSI   in   serial data in, MSB first
//     MISO   out  serial read data, MSB first; 0 when not shifting data
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   IDLE      | waiting for SS_n low (after SS_n has been seen high)
//   CHK_CMD   | sampling cmd[1] to choose write or read path
//   WRITE     | shifting cmd[0] + payload of a write-path frame
//   READ_ADD  | shifting a read-path frame with no valid read address
//   READ_DATA | shifting a read-path frame, then serialising read data
module spi_ram_bridge
    import spi_ram_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO
);

    localparam int PAYLOAD_W = payload_width(ADDR_W, DATA_W);
    localparam int FRAME_W   = PAYLOAD_W + CMD_W;
    localparam int CNT_W     = $clog2(FRAME_W + DATA_W + 1);

    // bit_cnt counts edges since CHK_CMD. Values of note:
    //   LAST_BIT: edge that samples the final payload bit
    //   LOAD_CNT: RAM data is available, first MISO bit is driven
    //   END_CNT : last MISO bit has been shown, frame finishes
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 2);
    localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] END_CNT  = CNT_W'(FRAME_W + DATA_W);

`ifdef SPI_RAM_AUTOINC_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
    endfunction
`endif

    state_t               state;
    logic [CNT_W-1:0]     bit_cnt;
    logic [PAYLOAD_W-1:0] shift_reg;
    logic                 cmd_hi;
    logic [ADDR_W-1:0]    wr_addr;
    logic [ADDR_W-1:0]    rd_addr;
    logic                 rd_addr_valid;
    // Set once SS_n is seen high; a new frame may only start when set, so a
    // select held low past the end of a frame does not start another one.
    logic                 armed;
    logic                 mem_we;
    logic [ADDR_W-1:0]    mem_addr;
    logic [DATA_W-1:0]    mem_wdata;
    logic [DATA_W-1:0]    mem_rdata;
    logic [DATA_W-1:0]    rd_shift;

    // Frame contents including the bit being sampled on this edge.
    logic [PAYLOAD_W:0]   frame_next;
    logic [CMD_W-1:0]     cmd_full;
    logic [ADDR_W-1:0]    frame_addr;
    logic [DATA_W-1:0]    frame_data;

    assign frame_next = {shift_reg, MOSI};
    assign cmd_full   = {cmd_hi, frame_next[PAYLOAD_W]};
    assign frame_addr = frame_next[ADDR_W-1:0];
    assign frame_data = frame_next[DATA_W-1:0];

    spi_ram_mem #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            MISO          <= 1'b0;
            shift_reg     <= '0;
            bit_cnt       <= '0;
            cmd_hi        <= 1'b0;
            wr_addr       <= '0;
            rd_addr       <= '0;
            rd_addr_valid <= 1'b0;
            armed         <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            rd_shift      <= '0;
        end else begin
            mem_we <= 1'b0;
            if (SS_n) begin
                armed <= 1'b1;
            end

            if (SS_n && (state != IDLE)) begin
                state   <= IDLE;
                MISO    <= 1'b0;
                bit_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        MISO    <= 1'b0;
                        bit_cnt <= '0;
                        if (!SS_n && armed) begin
                            state <= CHK_CMD;
                            armed <= 1'b0;
                        end
                    end

                    CHK_CMD: begin
                        MISO      <= 1'b0;
                        cmd_hi    <= MOSI;
                        shift_reg <= '0;
                        bit_cnt   <= '0;
                        if (!MOSI) begin
                            state <= WRITE;
                        end else if (rd_addr_valid) begin
                            state <= READ_DATA;
                        end else begin
                            state <= READ_ADD;
                        end
                    end

                    WRITE: begin
                        shift_reg <= frame_next[PAYLOAD_W-1:0];
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state   <= IDLE;
                            bit_cnt <= '0;
                            case (cmd_full)
                                CMD_WR_ADDR: wr_addr <= frame_addr;
                                CMD_WR_DATA: begin
                                    // Registered request; the RAM commits
                                    // it on the following edge.
                                    mem_we    <= 1'b1;
                                    mem_addr  <= wr_addr;
                                    mem_wdata <= frame_data;
`ifdef SPI_RAM_AUTOINC_EN
                                    wr_addr   <= next_addr(wr_addr);
`endif
                                end
                                default: ;
                            endcase
                        end
                    end

                    READ_ADD: begin
                        shift_reg <= frame_next[PAYLOAD_W-1:0];
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state   <= IDLE;
                            bit_cnt <= '0;
                            // A data read without a loaded address is dropped.
                            if (cmd_full == CMD_RD_ADDR) begin
                                rd_addr       <= frame_addr;
                                rd_addr_valid <= 1'b1;
                            end
                        end
                    end

                    READ_DATA: begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt < LAST_BIT) begin
                            shift_reg <= frame_next[PAYLOAD_W-1:0];
                        end else if (bit_cnt == LAST_BIT) begin
                            shift_reg <= frame_next[PAYLOAD_W-1:0];
                            if (cmd_full == CMD_RD_DATA) begin
                                mem_addr <= rd_addr;
                            end else begin
                                state   <= IDLE;
                                bit_cnt <= '0;
                                if (cmd_full == CMD_RD_ADDR) begin
                                    rd_addr       <= frame_addr;
                                    rd_addr_valid <= 1'b1;
                                end
                            end
                        end else if (bit_cnt == LOAD_CNT) begin
                            MISO     <= mem_rdata[DATA_W-1];
                            rd_shift <= {mem_rdata[DATA_W-2:0], 1'b0};
                        end else if (bit_cnt == END_CNT) begin
                            MISO    <= 1'b0;
                            state   <= IDLE;
                            bit_cnt <= '0;
`ifdef SPI_RAM_AUTOINC_EN
                            rd_addr <= next_addr(rd_addr);
`else
                            rd_addr_valid <= 1'b0;
`endif
                        end else if (bit_cnt > LOAD_CNT) begin
                            MISO     <= rd_shift[DATA_W-1];
                            rd_shift <= {rd_shift[DATA_W-2:0], 1'b0};
                        end
                        // bit_cnt == LAST_BIT+1: RAM read in flight, hold.
                    end

                    default: begin
                        state   <= IDLE;
                        MISO    <= 1'b0;
                        bit_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule
